mio_axis_st_rx_sink: RTL and testbench
======================================

Name: mio_axis_st_rx_sink

Overview:
AXI-Stream slave endpoint: accepts beats from an AXI-Stream master, buffers them in a small synchronous FIFO and presents them on a first-word-fall-through valid/ready read port.
Gives the stream a real receiving end with backpressure, packet accounting and oversize detection.
Sits as the DUT between the master and slave agents in the AXI-Stream bench. The slave agent drives the read-side handshake through a thin adapter.

Parameters:
DATA_WIDTH, 32, tdata width in bits; multiple of 8
ID_WIDTH, 4, tid width
DEST_WIDTH, 4, tdest width
USER_WIDTH, 1, tuser width
DEPTH, 8, FIFO entries; power of two, at least 2

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
s_tvalid  in  1  stream beat valid
s_tready  out  1  sink can accept a beat
s_tdata  in  DATA_WIDTH  beat data
s_tstrb  in  DATA_WIDTH/8  byte qualifier, stored
s_tkeep  in  DATA_WIDTH/8  byte keep
s_tlast  in  1  packet boundary
s_tid  in  ID_WIDTH  stream id
s_tdest  in  DEST_WIDTH  routing
s_tuser  in  USER_WIDTH  sideband
rd_valid  out  1  head entry available
rd_ready  in  1  consumer takes head entry
rd_data, rd_strb, rd_keep, rd_last, rd_id, rd_dest, rd_user  out  matching widths  head entry fields
rx_beat_cnt  out  32  accepted beats, wraps at 2^32
rx_pkt_cnt  out  32  accepted tlast beats, wraps at 2^32
fifo_level  out  $clog2(DEPTH)+1  current occupancy
pkt_oversize  out  1  sticky: FIFO filled with no tlast present (packet mode only)

Behaviour:
- Reset: all outputs 0 while reset_n=0, including s_tready, rd_valid, both counters, fifo_level and pkt_oversize. The cycle after reset deasserts, s_tready=1.
- Reset mid-packet discards all FIFO contents and partial packet state. No beat is accepted in the reset cycle.
- Accept: beat is accepted when s_tvalid & s_tready at a clk edge. s_tready = (fifo_level < DEPTH) and depends only on registered state. No combinational path from rd_ready or s_tvalid to s_tready.
- Null beats (s_tkeep all zero and s_tlast=0): handshaked and counted in rx_beat_cnt, but not stored. A null beat with tlast=1 is stored so the boundary is preserved.
- Latency: a beat accepted at edge N appears at the FIFO head with rd_valid=1 after edge N when the FIFO was empty; otherwise in order behind older entries.
- Read: head entry is consumed when rd_valid & rd_ready. rd_* fields stay stable while rd_valid=1 and rd_ready=0.
- Simultaneous push and pop: fifo_level unchanged; legal at any non-full, non-empty level.
- When full: s_tready=0 for that cycle even if rd_ready=1. A pop at full raises s_tready on the next cycle.
- When empty: rd_valid=0; rd_* hold their last values (not X).
- Pointers are $clog2(DEPTH)+1 bits with wrap bit. Full = MSBs differ and lower bits equal. Empty = pointers equal.
- rx_beat_cnt increments by 1 per accepted beat. rx_pkt_cnt increments by 1 per accepted beat with s_tlast=1. Both wrap silently.
- pkt_oversize clears only on reset.

Optional Feature:
MIO_AXIS_ST_RX_SINK_PKT_MODE_EN
- Defined (store-and-forward):
  - A counter tracks complete packets held in the FIFO: +1 on push with tlast, -1 on pop with rd_last, net 0 if both occur in the same cycle.
  - rd_valid = non-empty & (pkt_held > 0 | release). A complete packet becomes readable the cycle after its tlast is accepted.
  - Deadlock break: if FIFO is full and pkt_held = 0, set pkt_oversize and set release. release stays set until a popped beat has rd_last=1, so the oversize packet drains cut-through.
- Undefined: cut-through. rd_valid = non-empty; the pkt_held counter does not exist; pkt_oversize is tied to 0.

Decomposition:
- Package mio_axis_st_pkg holds:
  - default width localparams
  - parameterised beat struct type: data, strb, keep, last, id, dest, user
  - function keep_is_null(keep)
- Sub-module mio_axis_st_sync_fifo: generic width/depth FWFT synchronous FIFO with push, pop, full, empty and level. The sink instantiates it with the packed beat struct as payload.

Test Plan:
- Reset, then 1 beat (tdata=0xDEADBEEF, keep=0xF, last=1) with rd_ready=1 -> rd_valid=1 one cycle later with rd_data=0xDEADBEEF and rd_last=1; rx_beat_cnt=1; rx_pkt_cnt=1.
- rd_ready=0, stream 9 beats with DEPTH=8 -> 8 accepted; s_tready=0 with fifo_level=8; raise rd_ready for 1 cycle -> s_tready=1 next cycle and the 9th beat is accepted.
- Continuous s_tvalid and rd_ready for 100 beats -> 1 beat/cycle throughput; fifo_level constant; data order preserved.
- Null beat keep=0x0, last=0 between two data beats -> rd_* show only the 2 data beats; rx_beat_cnt=3.
- PKT_MODE_EN: send a 3-beat packet with a 2-cycle gap before tlast -> rd_valid stays 0 until the cycle after tlast is accepted. Send a 10-beat packet with rd_ready=0 -> pkt_oversize=1 when full; the packet then drains fully.
- Assert reset_n=0 mid-packet with 5 beats buffered -> next cycle fifo_level=0, rd_valid=0, counters=0.

Source files
------------

// File: rtl/mio_axis_st_pkg.sv
// Shared widths, default beat layout and helpers for the AXI-Stream sink.
package mio_axis_st_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ID_WIDTH_DEF   = 4;
  localparam int DEST_WIDTH_DEF = 4;
  localparam int USER_WIDTH_DEF = 1;
  localparam int DEPTH_DEF      = 8;
  // keep_is_null takes a zero-extended keep, so any width up to this works
  localparam int KEEP_MAX       = 128;

  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0]   data;
    logic [DATA_WIDTH_DEF/8-1:0] strb;
    logic [DATA_WIDTH_DEF/8-1:0] keep;
    logic                        last;
    logic [ID_WIDTH_DEF-1:0]     id;
    logic [DEST_WIDTH_DEF-1:0]   dest;
    logic [USER_WIDTH_DEF-1:0]   user;
  } axis_beat_t;

  function automatic logic keep_is_null(input logic [KEEP_MAX-1:0] keep);
    return keep == '0;
  endfunction

endpackage

// File: rtl/mio_axis_st_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head output holds the last popped
// word while empty so the read side never shows stale or unknown data.
module mio_axis_st_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] hold_q;
  logic             do_push;
  logic             do_pop;

  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty    = (wptr == rptr);
  assign level    = wptr - rptr;
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = empty ? hold_q : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset_n && do_push) mem[wptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr   <= '0;
      rptr   <= '0;
      hold_q <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) begin
        rptr   <= rptr + 1'b1;
        hold_q <= mem[rptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/mio_axis_st_rx_sink.sv
// AXI-Stream receive sink: buffered FWFT read port with beat/packet counters.
// Define MIO_AXIS_ST_RX_SINK_PKT_MODE_EN for store-and-forward with oversize detection.
module mio_axis_st_rx_sink
  import mio_axis_st_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ID_WIDTH   = ID_WIDTH_DEF,
  parameter int DEST_WIDTH = DEST_WIDTH_DEF,
  parameter int USER_WIDTH = USER_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_tstrb,
  input  logic [DATA_WIDTH/8-1:0] s_tkeep,
  input  logic                    s_tlast,
  input  logic [ID_WIDTH-1:0]     s_tid,
  input  logic [DEST_WIDTH-1:0]   s_tdest,
  input  logic [USER_WIDTH-1:0]   s_tuser,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [DATA_WIDTH/8-1:0] rd_strb,
  output logic [DATA_WIDTH/8-1:0] rd_keep,
  output logic                    rd_last,
  output logic [ID_WIDTH-1:0]     rd_id,
  output logic [DEST_WIDTH-1:0]   rd_dest,
  output logic [USER_WIDTH-1:0]   rd_user,
  output logic [31:0]             rx_beat_cnt,
  output logic [31:0]             rx_pkt_cnt,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    pkt_oversize
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int LW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KW-1:0]         strb;
    logic [KW-1:0]         keep;
    logic                  last;
    logic [ID_WIDTH-1:0]   id;
    logic [DEST_WIDTH-1:0] dest;
    logic [USER_WIDTH-1:0] user;
  } beat_t;

  localparam int BW = $bits(beat_t);

  beat_t         in_beat;
  beat_t         head;
  logic [BW-1:0] head_bits;
  logic          run_q;
  logic          full;
  logic          empty;
  logic          accept;
  logic          push;
  logic          pop;

  // run_q keeps s_tready low through reset and releases it one edge later
  assign s_tready = run_q & ~full;
  assign accept   = s_tvalid & s_tready;
  assign push     = accept & ~(keep_is_null(KEEP_MAX'(s_tkeep)) & ~s_tlast);
  assign pop      = rd_valid & rd_ready;

  assign in_beat = '{data: s_tdata, strb: s_tstrb, keep: s_tkeep, last: s_tlast,
                     id: s_tid, dest: s_tdest, user: s_tuser};

  mio_axis_st_sync_fifo #(
    .WIDTH (BW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (in_beat),
    .pop       (pop),
    .pop_data  (head_bits),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  assign head    = beat_t'(head_bits);
  assign rd_data = head.data;
  assign rd_strb = head.strb;
  assign rd_keep = head.keep;
  assign rd_last = head.last;
  assign rd_id   = head.id;
  assign rd_dest = head.dest;
  assign rd_user = head.user;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run_q       <= 1'b0;
      rx_beat_cnt <= '0;
      rx_pkt_cnt  <= '0;
    end else begin
      run_q <= 1'b1;
      if (accept) rx_beat_cnt <= rx_beat_cnt + 32'd1;
      if (accept && s_tlast) rx_pkt_cnt <= rx_pkt_cnt + 32'd1;
    end
  end

`ifdef MIO_AXIS_ST_RX_SINK_PKT_MODE_EN
  logic [LW-1:0] pkt_held;
  logic          rel_q;
  logic          oversize_q;
  logic          held_inc;
  logic          held_dec;

  assign held_inc = push & s_tlast;
  assign held_dec = pop & head.last;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pkt_held   <= '0;
      rel_q      <= 1'b0;
      oversize_q <= 1'b0;
    end else begin
      case ({held_inc, held_dec})
        2'b10:   pkt_held <= pkt_held + LW'(1);
        2'b01:   pkt_held <= pkt_held - LW'(1);
        default: pkt_held <= pkt_held;
      endcase
      // full with no complete packet can never make progress: drain it cut-through
      if (full && pkt_held == '0) begin
        oversize_q <= 1'b1;
        rel_q      <= 1'b1;
      end else if (held_dec) begin
        rel_q <= 1'b0;
      end
    end
  end

  assign rd_valid     = ~empty & ((pkt_held != '0) | rel_q);
  assign pkt_oversize = oversize_q;
`else
  assign rd_valid     = ~empty;
  assign pkt_oversize = 1'b0;
`endif

endmodule

// File: tb/tb_mio_axis_st_rx_sink.sv
// Self-checking bench: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_mio_axis_st_rx_sink;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] s_tdata;
  logic [3:0]  s_tstrb;
  logic [3:0]  s_tkeep;
  logic        s_tlast;
  logic [3:0]  s_tid;
  logic [3:0]  s_tdest;
  logic [0:0]  s_tuser;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic [3:0]  rd_strb;
  logic [3:0]  rd_keep;
  logic        rd_last;
  logic [3:0]  rd_id;
  logic [3:0]  rd_dest;
  logic [0:0]  rd_user;
  logic [31:0] rx_beat_cnt;
  logic [31:0] rx_pkt_cnt;
  logic [3:0]  fifo_level;
  logic        pkt_oversize;

  always #5 clk = ~clk;

  mio_axis_st_rx_sink dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .s_tdata      (s_tdata),
    .s_tstrb      (s_tstrb),
    .s_tkeep      (s_tkeep),
    .s_tlast      (s_tlast),
    .s_tid        (s_tid),
    .s_tdest      (s_tdest),
    .s_tuser      (s_tuser),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .rd_strb      (rd_strb),
    .rd_keep      (rd_keep),
    .rd_last      (rd_last),
    .rd_id        (rd_id),
    .rd_dest      (rd_dest),
    .rd_user      (rd_user),
    .rx_beat_cnt  (rx_beat_cnt),
    .rx_pkt_cnt   (rx_pkt_cnt),
    .fifo_level   (fifo_level),
    .pkt_oversize (pkt_oversize)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, got, exp, $time);
    end
  endtask

  // reference model: contents as a queue of beats plus a few scalars
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  keep;
    logic        last;
    logic [3:0]  id;
    logic [3:0]  dest;
    logic [0:0]  user;
  } mbeat_t;

  mbeat_t      mq[$];
  mbeat_t      m_hold = '0;
  int unsigned m_beats = 0;
  int unsigned m_pkts = 0;
  bit          m_run = 1'b0;
  bit          m_rel = 1'b0;
  bit          m_ovs = 1'b0;

  function automatic int m_lasts();
    int n = 0;
    foreach (mq[i]) if (mq[i].last) n++;
    return n;
  endfunction

  function automatic bit m_tready();
    return m_run && (mq.size() < DEPTH);
  endfunction

  function automatic bit m_rvalid();
`ifdef MIO_AXIS_ST_RX_SINK_PKT_MODE_EN
    return (mq.size() > 0) && (m_lasts() > 0 || m_rel);
`else
    return mq.size() > 0;
`endif
  endfunction

  always @(posedge clk) begin
    bit acc, pop, stuck;
    mbeat_t b;
    if (!reset_n) begin
      mq.delete();
      m_hold = '0; m_beats = 0; m_pkts = 0;
      m_run = 1'b0; m_rel = 1'b0; m_ovs = 1'b0;
    end else begin
      acc = s_tvalid && m_tready();
      pop = m_rvalid() && rd_ready;
`ifdef MIO_AXIS_ST_RX_SINK_PKT_MODE_EN
      stuck = (mq.size() == DEPTH) && (m_lasts() == 0);
`else
      stuck = 1'b0;
`endif
      if (pop) begin
        m_hold = mq.pop_front();
        if (m_hold.last) m_rel = 1'b0;
      end
      if (stuck) begin
        m_ovs = 1'b1;
        m_rel = 1'b1;
      end
      if (acc) begin
        m_beats++;
        if (s_tlast) m_pkts++;
        b = '{data: s_tdata, strb: s_tstrb, keep: s_tkeep, last: s_tlast,
              id: s_tid, dest: s_tdest, user: s_tuser};
        if (!(s_tkeep == 4'h0 && !s_tlast)) mq.push_back(b);
      end
      m_run = 1'b1;
    end
  end

  always @(negedge clk) begin
    mbeat_t h;
    if (chk_en) begin
      h = (mq.size() > 0) ? mq[0] : m_hold;
      chk("s_tready", s_tready, m_tready());
      chk("rd_valid", rd_valid, m_rvalid());
      chk("fifo_level", fifo_level, mq.size());
      chk("rx_beat_cnt", rx_beat_cnt, m_beats);
      chk("rx_pkt_cnt", rx_pkt_cnt, m_pkts);
      chk("pkt_oversize", pkt_oversize, m_ovs);
      chk("rd_data", rd_data, h.data);
      chk("rd_strb", rd_strb, h.strb);
      chk("rd_keep", rd_keep, h.keep);
      chk("rd_last", rd_last, h.last);
      chk("rd_id", rd_id, h.id);
      chk("rd_dest", rd_dest, h.dest);
      chk("rd_user", rd_user, h.user);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drv(input bit v, input logic [31:0] d, input logic [3:0] k, input bit l);
    s_tvalid = v;
    s_tdata  = d;
    s_tkeep  = k;
    s_tstrb  = ~k;
    s_tlast  = l;
    s_tid    = d[3:0];
    s_tdest  = d[7:4];
    s_tuser  = d[8];
  endtask

  initial begin
    int idx;
    bit acc;
    reset_n  = 1'b0;
    rd_ready = 1'b0;
    drv(1'b0, 32'h0, 4'h0, 1'b0);
    tick();
    chk_en = 1'b1;
    tick();
    chk("reset_tready", s_tready, 1'b0);
    chk("reset_rd_valid", rd_valid, 1'b0);
    chk("reset_level", fifo_level, 4'd0);
    chk("reset_beats", rx_beat_cnt, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("post_reset_tready", s_tready, 1'b1);

    // single beat with last
    rd_ready = 1'b1;
    drv(1'b1, 32'hDEADBEEF, 4'hF, 1'b1);
    tick();
    drv(1'b0, 32'h0, 4'h0, 1'b0);
    chk("single_rd_valid", rd_valid, 1'b1);
    chk("single_rd_data", rd_data, 32'hDEADBEEF);
    chk("single_rd_last", rd_last, 1'b1);
    chk("single_beats", rx_beat_cnt, 32'd1);
    chk("single_pkts", rx_pkt_cnt, 32'd1);
    tick();
    chk("single_drained", fifo_level, 4'd0);
    chk("empty_hold_data", rd_data, 32'hDEADBEEF);

    // fill to full and release one slot
    rd_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drv(1'b1, 32'(i + 1), 4'hF, 1'b1);
      tick();
    end
    chk("full_level", fifo_level, 4'd8);
    chk("full_tready", s_tready, 1'b0);
    chk("full_beats", rx_beat_cnt, 32'd9);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("pop_at_full_tready", s_tready, 1'b1);
    tick();
    drv(1'b0, 32'h0, 4'h0, 1'b0);
    chk("ninth_level", fifo_level, 4'd8);
    chk("ninth_beats", rx_beat_cnt, 32'd10);
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("drain_level", fifo_level, 4'd0);
    chk("drain_hold", rd_data, 32'd9);

    // null beat between two data beats
    rd_ready = 1'b0;
    drv(1'b1, 32'hA0A0A0A0, 4'hF, 1'b0); tick();
    drv(1'b1, 32'h11111111, 4'h0, 1'b0); tick();
    drv(1'b1, 32'hB0B0B0B0, 4'h3, 1'b1); tick();
    drv(1'b0, 32'h0, 4'h0, 1'b0);
    chk("null_level", fifo_level, 4'd2);
    chk("null_beats", rx_beat_cnt, 32'd13);
    chk("null_head", rd_data, 32'hA0A0A0A0);
    rd_ready = 1'b1;
    tick();
    chk("null_second", rd_data, 32'hB0B0B0B0);
    tick();
    chk("null_drained", fifo_level, 4'd0);

    // streaming throughput
    for (int i = 0; i < 100; i++) begin
      drv(1'b1, 32'(1000 + i), 4'hF, 1'b1);
      tick();
      chk("stream_level", fifo_level, 4'd1);
    end
    drv(1'b0, 32'h0, 4'h0, 1'b0);
    chk("stream_beats", rx_beat_cnt, 32'd113);
    tick();

`ifdef MIO_AXIS_ST_RX_SINK_PKT_MODE_EN
    // store-and-forward gating
    drv(1'b1, 32'h301, 4'hF, 1'b0); tick();
    chk("saf_hold1", rd_valid, 1'b0);
    drv(1'b0, 32'h0, 4'h0, 1'b0); tick();
    chk("saf_gap1", rd_valid, 1'b0);
    tick();
    chk("saf_gap2", rd_valid, 1'b0);
    drv(1'b1, 32'h302, 4'hF, 1'b0); tick();
    chk("saf_hold2", rd_valid, 1'b0);
    drv(1'b1, 32'h303, 4'hF, 1'b1); tick();
    chk("saf_release", rd_valid, 1'b1);
    chk("saf_head", rd_data, 32'h301);
    drv(1'b0, 32'h0, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) tick();

    // oversize packet
    idx = 0;
    rd_ready = 1'b0;
    for (int c = 0; c < 60 && idx < 10; c++) begin
      drv(1'b1, 32'(32'h400 + idx), 4'hF, idx == 9);
      rd_ready = pkt_oversize;
      acc = s_tready;
      tick();
      if (acc) idx++;
    end
    drv(1'b0, 32'h0, 4'h0, 1'b0);
    chk("oversize_all_accepted", idx, 10);
    chk("oversize_flag", pkt_oversize, 1'b1);
    rd_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("oversize_drained", fifo_level, 4'd0);
    chk("oversize_last", rd_data, 32'h409);
`endif

    // reset with a partial packet buffered
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 32'(32'h500 + i), 4'hF, 1'b0);
      tick();
    end
    chk("mid_level", fifo_level, 4'd5);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_level", fifo_level, 4'd0);
    chk("mid_rst_valid", rd_valid, 1'b0);
    chk("mid_rst_beats", rx_beat_cnt, 32'd0);
    chk("mid_rst_pkts", rx_pkt_cnt, 32'd0);
    chk("mid_rst_tready", s_tready, 1'b0);
    chk("mid_rst_ovs", pkt_oversize, 1'b0);
    drv(1'b0, 32'h0, 4'h0, 1'b0);
    reset_n = 1'b1;
    tick();
    chk("mid_after_tready", s_tready, 1'b1);

    // randomized traffic with shifting backpressure
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] k;
      int rr_bias;
      rr_bias = ((c / 200) % 3 == 1) ? 6 : 2;
      k = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
      drv($urandom_range(0, 3) != 0, $urandom, k, $urandom_range(0, 3) == 0);
      rd_ready = ($urandom_range(0, rr_bias) == 0);
      reset_n = ($urandom_range(0, 499) != 0);
      tick();
    end
    reset_n = 1'b1;
    drv(1'b0, 32'h0, 4'h0, 1'b0);
    rd_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
